// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: opcode constants, FSM state encoding,
// ALU operation and immediate-format encodings, plus an opcode-to-ImmSrc helper.
// Optional feature macro used by the controller: ILLEGAL_TRAP_EN.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluSlt = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ImmI = 2'b00,
    ImmS = 2'b01,
    ImmB = 2'b10
  } imm_src_e;

  // Stores and branches have their own immediate layouts; everything else uses I-type.
  function automatic imm_src_e imm_src_for(input logic [6:0] opcode);
    case (opcode)
      OpStore:  return ImmS;
      OpBranch: return ImmB;
      default:  return ImmI;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// alu_decoder: combinational ALU operation select from funct3/funct7[5].
// Ports:
//   opcode_i   - instruction opcode (sub only applies to register-register ops)
//   funct3_i   - instruction funct3
//   funct7_5_i - instruction bit 30 (funct7[5])
//   alu_ctrl_o - ALU operation encoding
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output alu_ctrl_e  alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = AluAdd;
    case (funct3_i)
      // Bit 30 is part of the immediate for I-ALU ops, so it only selects sub for R-type.
      3'b000:  alu_ctrl_o = (opcode_i == OpR && funct7_5_i) ? AluSub : AluAdd;
      3'b111:  alu_ctrl_o = AluAnd;
      3'b110:  alu_ctrl_o = AluOr;
      3'b010:  alu_ctrl_o = AluSlt;
      default: alu_ctrl_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM control unit for a multicycle RV32 subset datapath.
// FETCH -> DECODE -> EXEC -> {MEM} -> {WB} -> FETCH; instret counts retired instructions.
// Optional: define ILLEGAL_TRAP_EN to send unknown opcodes to a TRAP state that only reset
// leaves; otherwise unknown opcodes retire as NOPs.
// Ports:
//   clk, rst (sync, active-low), instr, EQ, mem_ack           - inputs
//   PCWrite, PCsrc, IRWrite, RegWrite, MemReq, MemWE, ALUsrc,
//   ImmSrc, ALUctrl, ResultSrc                                 - datapath controls
//   state, instret                                             - status
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic                  EQ,
  input  logic                  mem_ack,
  output logic                  PCWrite,
  output logic                  PCsrc,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic                  MemReq,
  output logic                  MemWE,
  output logic                  ALUsrc,
  output logic [1:0]            ImmSrc,
  output logic [2:0]            ALUctrl,
  output logic                  ResultSrc,
  output logic [2:0]            state,
  output logic [DATA_WIDTH-1:0] instret
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] instret_q;
  logic                  retire;

  logic [6:0] opcode;
  logic       is_alu, is_load, is_store;
  alu_ctrl_e  dec_alu_ctrl;

  logic pc_write, ir_write, reg_write, mem_req, mem_we;

  assign opcode   = instr[6:0];
  assign is_alu   = (opcode == OpR) || (opcode == OpIAlu);
  assign is_load  = (opcode == OpLoad);
  assign is_store = (opcode == OpStore);

  logic unused_instr;
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  alu_decoder u_alu_decoder (
    .opcode_i   (opcode),
    .funct3_i   (instr[14:12]),
    .funct7_5_i (instr[30]),
    .alu_ctrl_o (dec_alu_ctrl)
  );

  // Operand/format selects are steady decodes of instr; only strobes depend on state.
  always_comb begin
    ImmSrc = imm_src_for(opcode);
    if (is_alu) begin
      ALUctrl = dec_alu_ctrl;
      ALUsrc  = (opcode == OpIAlu);
    end else if (opcode == OpBranch) begin
      ALUctrl = AluSub;
      ALUsrc  = 1'b0;
    end else begin
      ALUctrl = AluAdd;
      ALUsrc  = is_load || is_store;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    PCsrc     = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ResultSrc = 1'b0;
    retire    = 1'b0;
    case (state_q)
      StFetch: begin
        ir_write = 1'b1;
        state_d  = StDecode;
      end
      StDecode: state_d = StExec;
      StExec: begin
        if (is_alu) begin
          state_d = StWb;
        end else if (is_load || is_store) begin
          state_d = StMem;
        end else if (opcode == OpBranch) begin
          pc_write = 1'b1;
          PCsrc    = EQ;
          retire   = 1'b1;
          state_d  = StFetch;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d  = StTrap;
`else
          pc_write = 1'b1;
          retire   = 1'b1;
          state_d  = StFetch;
`endif
        end
      end
      StMem: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ack) begin
          if (is_store) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = StFetch;
          end else begin
            state_d  = StWb;
          end
        end
      end
      StWb: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        ResultSrc = is_load;
        retire    = 1'b1;
        state_d   = StFetch;
      end
`ifdef ILLEGAL_TRAP_EN
      StTrap: state_d = StTrap;
`endif
      default: state_d = StFetch;
    endcase
  end

  // Reset wins over retire, so an aborted MEM transaction never counts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StFetch;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + DATA_WIDTH'(1);
    end
  end

  // Strobes are held low for the whole time reset is asserted.
  assign PCWrite  = pc_write  & rst;
  assign IRWrite  = ir_write  & rst;
  assign RegWrite = reg_write & rst;
  assign MemReq   = mem_req   & rst;
  assign MemWE    = mem_we    & rst;

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam logic [31:0] InsAdd  = 32'h003100B3;
  localparam logic [31:0] InsSub  = 32'h403100B3;
  localparam logic [31:0] InsAnd  = 32'h003170B3;
  localparam logic [31:0] InsOr   = 32'h003160B3;
  localparam logic [31:0] InsSlt  = 32'h003120B3;
  localparam logic [31:0] InsAddi = 32'hC0010093;
  localparam logic [31:0] InsBeq  = 32'h00208463;
  localparam logic [31:0] InsLw   = 32'h00012083;
  localparam logic [31:0] InsSw   = 32'h00112023;
  localparam logic [31:0] InsBad  = 32'h0000007F;

  logic        clk, rst, EQ, mem_ack;
  logic [31:0] instr;
  logic        PCWrite, PCsrc, IRWrite, RegWrite, MemReq, MemWE, ALUsrc, ResultSrc;
  logic [1:0]  ImmSrc;
  logic [2:0]  ALUctrl, state;
  logic [31:0] instret;

  logic        w_pcw, w_pcs, w_irw, w_rw, w_mr, w_mwe, w_as, w_rs;
  logic [1:0]  w_imm;
  logic [2:0]  w_alu, w_state;
  logic [3:0]  instret_w;

  int checks = 0;
  int failures = 0;
  int unsigned exp_ret = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .EQ(EQ), .mem_ack(mem_ack),
    .PCWrite(PCWrite), .PCsrc(PCsrc), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemReq(MemReq), .MemWE(MemWE), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc),
    .ALUctrl(ALUctrl), .ResultSrc(ResultSrc), .state(state), .instret(instret)
  );

  // Narrow counter copy to exercise wrap-around in a short run.
  multicycle_ctrl #(.DATA_WIDTH(4)) dut_w (
    .clk(clk), .rst(rst), .instr(instr), .EQ(EQ), .mem_ack(mem_ack),
    .PCWrite(w_pcw), .PCsrc(w_pcs), .IRWrite(w_irw), .RegWrite(w_rw),
    .MemReq(w_mr), .MemWE(w_mwe), .ALUsrc(w_as), .ImmSrc(w_imm),
    .ALUctrl(w_alu), .ResultSrc(w_rs), .state(w_state), .instret(instret_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    cyc();
    chk("rst_state", 32'(state), 32'(StFetch));
    chk("rst_instret", instret, 32'd0);
    chk("rst_irwrite", 32'(IRWrite), 32'd0);
    chk("rst_pcwrite", 32'(PCWrite), 32'd0);
    rst = 1'b1;
    exp_ret = 0;
    #1;
  endtask

  task automatic run_alu(input string tag, input logic [31:0] ins, input logic [2:0] ctl,
                         input logic src);
    instr = ins;
    #1;
    chk({tag, "_fetch_ir"}, 32'(IRWrite), 32'd1);
    cyc();
    chk({tag, "_dec_state"}, 32'(state), 32'(StDecode));
    chk({tag, "_dec_ir"}, 32'(IRWrite), 32'd0);
    cyc();
    chk({tag, "_exec_state"}, 32'(state), 32'(StExec));
    chk({tag, "_exec_alu"}, 32'(ALUctrl), 32'(ctl));
    chk({tag, "_exec_src"}, 32'(ALUsrc), 32'(src));
    chk({tag, "_exec_rw"}, 32'(RegWrite), 32'd0);
    cyc();
    chk({tag, "_wb_state"}, 32'(state), 32'(StWb));
    chk({tag, "_wb_rw"}, 32'(RegWrite), 32'd1);
    chk({tag, "_wb_pcw"}, 32'(PCWrite), 32'd1);
    chk({tag, "_wb_res"}, 32'(ResultSrc), 32'd0);
    chk({tag, "_wb_alu"}, 32'(ALUctrl), 32'(ctl));
    cyc();
    exp_ret++;
    chk({tag, "_instret"}, instret, exp_ret);
    chk({tag, "_ret_state"}, 32'(state), 32'(StFetch));
  endtask

  task automatic run_beq(input string tag, input logic eq);
    instr = InsBeq;
    EQ = eq;
    #1;
    chk({tag, "_fetch_ir"}, 32'(IRWrite), 32'd1);
    cyc();
    chk({tag, "_dec_imm"}, 32'(ImmSrc), 32'b10);
    cyc();
    chk({tag, "_exec_pcw"}, 32'(PCWrite), 32'd1);
    chk({tag, "_exec_pcsrc"}, 32'(PCsrc), 32'(eq));
    chk({tag, "_exec_alu"}, 32'(ALUctrl), 32'b001);
    chk({tag, "_exec_rw"}, 32'(RegWrite), 32'd0);
    cyc();
    exp_ret++;
    chk({tag, "_instret"}, instret, exp_ret);
    chk({tag, "_ret_state"}, 32'(state), 32'(StFetch));
    EQ = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    instr = InsAdd;
    EQ = 1'b0;
    mem_ack = 1'b0;
    do_reset();

    // add right after reset: IRWrite in cycle 1, RegWrite in cycle 4
    run_alu("add", InsAdd, 3'b000, 1'b0);
    run_alu("sub", InsSub, 3'b001, 1'b0);
    run_alu("and", InsAnd, 3'b010, 1'b0);
    run_alu("or", InsOr, 3'b011, 1'b0);
    run_alu("slt", InsSlt, 3'b101, 1'b0);
    run_alu("addi", InsAddi, 3'b000, 1'b1);

    run_beq("beq1", 1'b1);
    run_beq("beq0", 1'b0);

    // lw: ack arrives in the third MEM cycle
    instr = InsLw;
    #1;
    cyc();
    chk("lw_dec_imm", 32'(ImmSrc), 32'b00);
    cyc();
    chk("lw_exec_src", 32'(ALUsrc), 32'd1);
    chk("lw_exec_alu", 32'(ALUctrl), 32'b000);
    cyc();
    for (int i = 0; i < 3; i++) begin
      mem_ack = (i == 2);
      #1;
      chk("lw_mem_state", 32'(state), 32'(StMem));
      chk("lw_mem_req", 32'(MemReq), 32'd1);
      chk("lw_mem_we", 32'(MemWE), 32'd0);
      chk("lw_mem_rw", 32'(RegWrite), 32'd0);
      chk("lw_mem_pcw", 32'(PCWrite), 32'd0);
      cyc();
    end
    mem_ack = 1'b0;
    #1;
    chk("lw_wb_state", 32'(state), 32'(StWb));
    chk("lw_wb_res", 32'(ResultSrc), 32'd1);
    chk("lw_wb_rw", 32'(RegWrite), 32'd1);
    chk("lw_wb_req", 32'(MemReq), 32'd0);
    cyc();
    exp_ret++;
    chk("lw_instret", instret, exp_ret);

    // sw: ack in the second MEM cycle, retires from MEM
    instr = InsSw;
    #1;
    cyc();
    chk("sw_dec_imm", 32'(ImmSrc), 32'b01);
    cyc();
    cyc();
    for (int i = 0; i < 2; i++) begin
      mem_ack = (i == 1);
      #1;
      chk("sw_mem_req", 32'(MemReq), 32'd1);
      chk("sw_mem_we", 32'(MemWE), 32'd1);
      chk("sw_mem_rw", 32'(RegWrite), 32'd0);
      chk("sw_mem_pcw", 32'(PCWrite), 32'(i == 1));
      chk("sw_mem_pcsrc", 32'(PCsrc), 32'd0);
      cyc();
    end
    mem_ack = 1'b0;
    exp_ret++;
    chk("sw_state", 32'(state), 32'(StFetch));
    chk("sw_instret", instret, exp_ret);

    // Unknown opcode
    instr = InsBad;
    #1;
    cyc();
    cyc();
`ifdef ILLEGAL_TRAP_EN
    chk("bad_exec_pcw", 32'(PCWrite), 32'd0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("trap_state", 32'(state), 32'(StTrap));
      chk("trap_strobes", 32'({PCWrite, IRWrite, RegWrite, MemReq, MemWE}), 32'd0);
      chk("trap_instret", instret, exp_ret);
      cyc();
    end
    do_reset();
`else
    chk("bad_exec_pcw", 32'(PCWrite), 32'd1);
    chk("bad_exec_pcsrc", 32'(PCsrc), 32'd0);
    cyc();
    exp_ret++;
    chk("bad_state", 32'(state), 32'(StFetch));
    chk("bad_instret", instret, exp_ret);
`endif

    // Reset in the middle of a MEM wait aborts without retiring
    instr = InsLw;
    #1;
    cyc();
    cyc();
    cyc();
    chk("abort_mem_req", 32'(MemReq), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_req_forced", 32'(MemReq), 32'd0);
    cyc();
    chk("abort_state", 32'(state), 32'(StFetch));
    chk("abort_instret", instret, 32'd0);
    chk("abort_req", 32'(MemReq), 32'd0);
    rst = 1'b1;
    exp_ret = 0;
    #1;
    chk("abort_first_ir", 32'(IRWrite), 32'd1);

    // Narrow counter wraps from 15 to 0 on the 16th retire
    for (int k = 1; k <= 16; k++) begin
      run_beq("wrap", 1'b0);
      chk("wrap_w", 32'(instret_w), exp_ret & 32'hF);
    end
    chk("wrap_main", instret, 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the instret counter.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  synchronous, active-low reset; rst=0 sampled on a clk edge resets the block.
REQ-004 instr  input  32  current instruction word.
REQ-005 EQ  input  1  ALU zero/equal flag.
REQ-006 mem_ack  input  1  data-memory completion strobe.
REQ-007 PCWrite  output  1  PC register load enable.
REQ-008 PCsrc  output  1  0 = PC+4, 1 = PC+immOp.
REQ-009 IRWrite  output  1  instruction register load enable.
REQ-010 RegWrite  output  1  regfile WE3.
REQ-011 MemReq  output  1  data-memory request.
REQ-012 MemWE  output  1  data-memory write enable.
REQ-013 ALUsrc  output  1  0 = register operand, 1 = immOp.
REQ-014 ImmSrc  output  2  00 I-type, 01 S-type, 10 B-type.
REQ-015 ALUctrl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-016 ResultSrc  output  1  0 = ALU result, 1 = memory read data to WD3.
REQ-017 state  output  3  current FSM state encoding.
REQ-018 instret  output  DATA_WIDTH  count of retired instructions.

Function
REQ-019 The FSM SHALL use the states FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-020 FETCH SHALL assert IRWrite for one cycle and then go to DECODE.
REQ-021 DECODE SHALL last one cycle, drive ImmSrc from the opcode, and go to EXEC.
REQ-022 EXEC for opcode 0110011 (R) or 0010011 (I-ALU) SHALL drive ALUsrc and ALUctrl, then go to WB.
REQ-023 EXEC for 0000011 (load) or 0100011 (store) SHALL set ALUsrc=1 and ALUctrl=add, then go to MEM.
REQ-024 EXEC for 1100011 (branch) SHALL set ALUctrl=sub, PCWrite=1 and PCsrc=EQ, retire, then go to FETCH.
REQ-025 The ALUctrl decode SHALL be:
- funct3 000: sub when op=0110011 and funct7[5]=1, otherwise add.
- funct3 111: and.
- funct3 110: or.
- funct3 010: slt.
- any other funct3: add.
REQ-026 MEM SHALL hold MemReq=1, with MemWE=1 for store and 0 for load, stable every cycle until mem_ack=1 is sampled.
REQ-027 MEM SHALL leave after the mem_ack cycle: a store retires (PCWrite=1, PCsrc=0) and goes to FETCH; a load goes to WB.
REQ-028 mem_ack sampled outside MEM SHALL be ignored.
REQ-029 WB SHALL assert RegWrite=1, PCWrite=1 and PCsrc=0, set ResultSrc=1 for a load and 0 otherwise, retire, then go to FETCH.
REQ-030 Latency SHALL be:
- ALU instruction: 4 cycles.
- Branch: 3 cycles.
- Store: 4+N cycles.
- Load: 5+N cycles.
- N = cycles before mem_ack.
REQ-031 Outputs SHALL be combinational from state and instr, with every strobe at 0 in any state not listed as asserting it.
REQ-032 instret SHALL increment by 1 in each retire cycle, wrap from 2^DATA_WIDTH-1 to 0, and never increment twice in one cycle.
REQ-033 An unknown opcode in EXEC SHALL behave as set by REQ-037 and REQ-038.

Reset
REQ-034 rst=0 at a clk edge SHALL set state=FETCH and instret=0, and SHALL abort any MEM transaction without retiring it.
REQ-035 While rst=0, all strobes SHALL be forced to 0: PCWrite, IRWrite, RegWrite, MemReq and MemWE.
REQ-036 The first IRWrite SHALL occur in the first cycle after rst returns to 1.

Configuration
REQ-037 With ILLEGAL_TRAP_EN defined:
- An unknown opcode in EXEC SHALL go to TRAP.
- TRAP SHALL hold every strobe at 0 and SHALL not change instret.
- Only reset SHALL leave TRAP.
REQ-038 Without ILLEGAL_TRAP_EN:
- An unknown opcode SHALL retire as a NOP (PCWrite=1, PCsrc=0) and go to FETCH.
- The TRAP state SHALL be unreachable.

Structure
REQ-039 A shared package SHALL hold:
- the opcode constants;
- the state enum;
- the ALUctrl and ImmSrc encodings.
REQ-040 A combinational sub-module alu_decoder SHALL implement REQ-025; the FSM SHALL remain in multicycle_ctrl.

Verification
REQ-041 add x1,x2,x3 (0x003100B3) after reset -> IRWrite in cycle 1, RegWrite=1 and ALUctrl=000 in cycle 4, instret=1.
REQ-042 sub (funct7=0100000) -> ALUctrl=001; and/or/slt -> 010/011/101.
REQ-043 beq with EQ=1 -> PCWrite=1 and PCsrc=1 in cycle 3; with EQ=0 -> PCsrc=0; ImmSrc=10.
REQ-044 lw with mem_ack delayed 3 cycles -> MemReq=1, MemWE=0 held for 3 cycles, then WB with ResultSrc=1 and RegWrite=1; sw -> MemWE=1, no RegWrite, ImmSrc=01.
REQ-045 rst=0 mid-MEM -> state=FETCH, MemReq=0 and instret=0 next cycle; instret preset near wrap -> 0xFFFFFFFF then 0 on the next retire.
REQ-046 Opcode 0x7F -> TRAP with strobes held at 0 when ILLEGAL_TRAP_EN is defined; a NOP retire with instret+1 when it is not.
